// File: rtl/arb_pkg.sv
// Shared constants and grant-vector helpers for the arbiter request front end.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SRC_W = 2;

    // Returns 1 only when exactly one bit of the grant vector is set.
    function automatic logic onehot_check(input logic [N_REQ-1:0] vec);
        return $countones(vec) == 1;
    endfunction

    // Returns the index of the set bit. The caller must first confirm that vec is one-hot.
    function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] vec);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (vec[i]) idx = SRC_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Per-requester single-clock FIFO. Pointers wrap naturally, and count is one bit wider than the pointers.
module req_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy state. A push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The storage array has no reset. Reset clears the occupancy count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/arb_req_buffer.sv
// Request-side front end for the 4-way arbiter. It holds per-requester FIFOs, drives REQ,
// consumes the one-hot GNT, and loads a single registered valid/ready output slot.
module arb_req_buffer
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          in_valid,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    output logic [N_REQ-1:0]          in_ready,
    output logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          GNT,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      gnt_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count    [N_REQ];
    logic [DATA_W-1:0] pop_data [N_REQ];
    logic [N_REQ-1:0]  full;
    logic [N_REQ-1:0]  empty;
    logic [N_REQ-1:0]  push;
    logic [N_REQ-1:0]  pop;
    logic [SRC_W-1:0]  gnt_idx;
    logic              stall;
    logic              gnt_ok;

    assign stall   = out_valid & ~out_ready;
    assign gnt_idx = onehot_to_idx(GNT);
    assign gnt_ok  = onehot_check(GNT) && (count[gnt_idx] != '0) && !stall;
    assign gnt_err = (GNT != '0) && !onehot_check(GNT);

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_fifo
        assign push[i]     = in_valid[i] & ~full[i];
        assign pop[i]      = gnt_ok & GNT[i];
        assign in_ready[i] = ~full[i];
        assign REQ[i]      = ~empty[i] & ~stall;

        req_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (in_data[i*DATA_W +: DATA_W]),
            .pop       (pop[i]),
            .pop_data  (pop_data[i]),
            .count     (count[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // Output slot. A load takes priority over a drain, so a slot that drains and loads in the same cycle passes one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (gnt_ok) begin
            out_valid <= 1'b1;
            out_data  <= pop_data[gnt_idx];
            out_src   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_req_buffer.sv
// Randomised and directed checks of arb_req_buffer against a queue-based reference model.
module tb_arb_req_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [31:0]   in_data;
    logic [3:0]    in_ready;
    logic [3:0]    REQ;
    logic [3:0]    GNT;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [1:0]    out_src;
    logic          out_ready;
    logic          gnt_err;

    always #5 clk = ~clk;

    arb_req_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .REQ       (REQ),
        .GNT       (GNT),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .gnt_err   (gnt_err)
    );

    // Reference model: one queue per requester plus the output slot.
    logic [7:0] mq [4][$];
    logic       m_ov;
    logic [7:0] m_od;
    logic [1:0] m_os;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_ov = 1'b0;
        m_od = '0;
        m_os = '0;
    endtask

    task automatic model_edge(input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] g, input logic r);
        logic       stall;
        logic [3:0] acc;
        int         k;
        logic [7:0] w;
        stall = m_ov && !r;
        for (int i = 0; i < 4; i++) acc[i] = v[i] && (mq[i].size() < int'(DEPTH));
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        if (($countones(g) == 1) && !stall && (mq[k].size() > 0)) begin
            w    = mq[k].pop_front();
            m_ov = 1'b1;
            m_od = w;
            m_os = 2'(k);
        end else if (r) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(d[i*8 +: 8]);
    endtask

    // Apply one cycle of inputs. Combinational outputs are checked before the edge and registered outputs after it.
    task automatic step(input logic [3:0] v, input logic [31:0] d,
                        input logic [3:0] g, input logic r);
        logic [3:0] e_rdy;
        logic [3:0] e_req;
        in_valid  = v;
        in_data   = d;
        GNT       = g;
        out_ready = r;
        #1;
        for (int i = 0; i < 4; i++) begin
            e_rdy[i] = mq[i].size() < int'(DEPTH);
            e_req[i] = (mq[i].size() > 0) && !(m_ov && !r);
        end
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        check("req", 32'(REQ), 32'(e_req));
        check("gnt_err", 32'(gnt_err), 32'($countones(g) > 1));
        @(posedge clk);
        model_edge(v, d, g, r);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_src", 32'(out_src), 32'(m_os));
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'hF);
        check("rst_req", 32'(REQ), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
    endtask

    initial begin
        logic [3:0]  v;
        logic [3:0]  g;
        logic [31:0] d;
        logic        r;
        int          sel;

        model_clear();
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = 32'h1234_5678;
        GNT       = 4'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Single requester on port 3.
        step(4'b1000, 32'hA500_0000, 4'b0000, 1'b1);
        step(4'b0000, 32'h0, 4'b1000, 1'b1);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_src", 32'(out_src), 32'h3);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Push five words into port 1 without grants. The fifth push must be refused.
        for (int i = 0; i < 5; i++) step(4'b0010, 32'(8'h10 + i) << 8, 4'b0000, 1'b1);
        check("full_ready", 32'(in_ready[1]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 32'h0, 4'b0010, 1'b1);
            check("full_order", 32'(out_data), 32'(8'h10 + i));
        end
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Stall: hold a full slot with out_ready low, then release it.
        step(4'b0010, 32'h0000_3300, 4'b0000, 1'b1);
        step(4'b0010, 32'h0000_4400, 4'b0010, 1'b1);
        step(4'b0000, 32'h0, 4'b0010, 1'b0);
        check("stall_hold", 32'(out_data), 32'h33);
        step(4'b0000, 32'h0, 4'b0010, 1'b1);
        check("stall_resume", 32'(out_data), 32'h44);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Back-to-back rotating grants produce one word per cycle.
        step(4'b1111, 32'hD3C2_B1A0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 32'h0, 4'(1 << i), 1'b1);
            check("b2b_src", 32'(out_src), 32'(i));
        end
        step(4'b0000, 32'h0, 4'b0000, 1'b1);

        // An illegal grant must not pop either FIFO.
        step(4'b0110, 32'h0077_6600, 4'b0000, 1'b1);
        step(4'b0000, 32'h0, 4'b0110, 1'b1);
        step(4'b0000, 32'h0, 4'b0100, 1'b1);
        check("illegal_nopop", 32'(out_data), 32'h77);

        // Randomised traffic, with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      g = 4'(1 << $urandom_range(0, 3));
            else if (sel < 8) g = 4'h0;
            else              g = 4'($urandom);
            v = 4'($urandom) & 4'($urandom);
            d = $urandom;
            r = ($urandom_range(0, 3) != 0);
            step(v, d, g, r);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_clear();
                check_reset_outputs();
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_req_buffer.md
Name: arb_req_buffer

Overview:
- Request-side front end for the 4-way round-robin arbiter.
- Holds up to DEPTH words per requester in private FIFOs and drives REQ[i] while FIFO i holds data and the shared output can accept a word.
- Consumes the arbiter's one-hot GNT, pops the granted FIFO into a single registered output slot, and presents that slot on a valid/ready interface to the shared resource.

Parameters:
- N_REQ, 4, number of requesters; fixed to match the 4-bit REQ/GNT.
- DATA_W, 8, payload width per requester.
- DEPTH, 4, entries per requester FIFO; must be a power of two and at least 2.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N_REQ  per-requester write strobe.
- in_data  input  N_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_REQ  FIFO i not full.
- REQ  output  N_REQ  request vector to the arbiter.
- GNT  input  N_REQ  one-hot grant from the arbiter.
- out_valid  output  1  output slot holds a word.
- out_data  output  DATA_W  payload in the output slot.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the slot this cycle.
- gnt_err  output  1  one-cycle pulse: GNT was not zero-or-one-hot.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All FIFOs empty and pointers/counts cleared.
  - out_valid=0, out_data=0, out_src=0, gnt_err=0.
  - in_ready=all 1s, REQ=0.
  - Release of rst_n is synchronised by the clock; the first push is accepted on the first rising edge with rst_n=1.
- Push:
  - A word is written to FIFO i when in_valid[i] & in_ready[i] at a rising edge.
  - in_ready[i] = count[i] != DEPTH, taken from registered state; a full FIFO refuses a push even if it is popped in the same cycle.
  - Push and pop on a non-full FIFO in the same cycle are both performed; the count is unchanged.
- Stall:
  - stall = out_valid & ~out_ready.
- REQ:
  - REQ[i] = (count[i] != 0) & ~stall.
  - REQ is combinational from the registered counts and out_ready.
- Grant acceptance:
  - gnt_ok = GNT is exactly one-hot, and the granted FIFO is non-empty, and ~stall.
  - When gnt_ok, on the same rising edge:
    - pop the head of the granted FIFO k into out_data;
    - out_src <= k;
    - out_valid <= 1.
  - Latency: push to earliest out_valid is 2 cycles (count updates, then REQ; the arbiter's own latency adds to this).
- Ignored grants:
  - A grant that fails gnt_ok (empty FIFO or stall) is dropped without error. REQ stays up and the arbiter re-grants later.
  - GNT=0 means no action.
- Illegal grant:
  - GNT with two or more bits set: no pop, and gnt_err=1 for that cycle.
  - The output slot drains normally.
- Output slot:
  - When out_valid & out_ready and no new load, out_valid <= 0.
  - Simultaneous drain and load overwrite the slot back-to-back, giving one word per cycle at full throughput.
  - out_data and out_src stay stable while stall=1.
- Wrap-around:
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Reset mid-operation: all buffered words are discarded immediately; no partial word is presented after reset.
- Ordering: words from a single requester leave in push order. There is no ordering guarantee across requesters beyond the arbiter's grant order.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=4;
  - SRC_W=2;
  - function onehot_check(vec) returning 1 for exactly one bit set;
  - function onehot_to_idx(vec) returning the SRC_W-bit index.
- Sub-module req_fifo (DATA_W, DEPTH):
  - single-clock synchronous FIFO;
  - ports: clk, rst_n, push, push_data, pop, pop_data, count, full, empty.
  - Instantiated N_REQ times with a generate loop.
- Top level holds the REQ/gnt_ok logic and the output slot.

Test Plan:
- Reset: rst_n=0 with in_valid=4'b1111 -> in_ready=4'b1111, REQ=0, out_valid=0. No push occurs until after release.
- Single requester: push 8'hA5 on port 3, GNT=4'b1000 on the cycle after REQ=4'b1000 -> out_valid=1, out_data=8'hA5, out_src=3, REQ[3] drops to 0.
- Full FIFO: push 5 words on port 1 with no grants -> in_ready[1]=0 after the 4th push, the 5th word is not stored, and exactly 4 words later emerge in order.
- Stall: out_ready=0 with the slot full and GNT=4'b0010 -> REQ=0, no pop, the slot is unchanged. Set out_ready=1 -> REQ reasserts and the next grant loads the slot.
- Back-to-back: REQ=4'b1111, arbiter grants rotate 0,1,2,3, out_ready=1 -> one word per cycle, out_src sequence 0,1,2,3.
- Illegal grant: GNT=4'b0110 -> gnt_err=1 for one cycle, no FIFO count changes. Reset asserted mid-stream -> all counts 0 and out_valid=0 asynchronously.
